wb_retire_queue: RTL and testbench
==================================

WB_RETIRE_QUEUE -- requirements
Module: wb_retire_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register data and result width.
REQ-002 SHALL have parameter REG_AW, default 5, meaning register address width; the register count NREG is 2**REG_AW.
REQ-003 SHALL have parameter PC_W, default 32, meaning PC width.
REQ-004 SHALL have parameter DEPTH, default 2, meaning retire queue entries; legal range 1..8.
REQ-005 SHALL have port: clk  input  1  clock.
REQ-006 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port: ms_to_ws_valid  input  1  memory stage offers an instruction.
REQ-008 SHALL have port: ms_gr_we  input  1  instruction writes a register.
REQ-009 SHALL have port: ms_dest  input  REG_AW  destination register.
REQ-010 SHALL have port: ms_result  input  DATA_W  writeback value.
REQ-011 SHALL have port: ms_pc  input  PC_W  instruction PC.
REQ-012 SHALL have port: ms_excp  input  1  instruction carries an exception.
REQ-013 SHALL have port: ws_allowin  output  1  queue accepts an instruction this cycle.
REQ-014 SHALL have port: rf_ready  input  1  register file write port is free this cycle.
REQ-015 SHALL have port: rf_we / rf_waddr / rf_wdata  output  1/REG_AW/DATA_W  register file write.
REQ-016 SHALL have port: fwd_raddr  input  REG_AW  decode forwarding query address.
REQ-017 SHALL have port: fwd_hit / fwd_data  output  1/DATA_W  forwarding result.
REQ-018 SHALL have port: pending_mask  output  NREG  bit r set means a write to register r is queued.
REQ-019 SHALL have port: ws_flush / ws_flush_pc  output  1/PC_W  exception retire pulse and its PC.

Function
REQ-020 SHALL hold instructions in a circular FIFO with head pointer, tail pointer and count; the pointers wrap modulo DEPTH.
REQ-021 SHALL enqueue an instruction on the clk edge where ms_to_ws_valid && ws_allowin.
REQ-022 SHALL set ws_allowin = !ws_flush && (count<DEPTH || retire); enqueue and retire in the same cycle when full SHALL leave count unchanged.
REQ-023 SHALL assert retire when the head is valid and either (gr_we && !excp && rf_ready) or !gr_we or excp.
REQ-024 SHALL drive rf_we = head valid && head gr_we && !head excp && rf_ready, with rf_waddr/rf_wdata taken from the head entry.
REQ-025 SHALL give a minimum latency of 1 cycle: an instruction accepted at edge N can drive rf_we in the cycle after edge N.
REQ-026 SHALL, while rf_ready=0, hold the head entry and keep accepting new instructions until the queue is full.
REQ-027 SHALL drive ws_flush=1 combinationally when the head is valid with excp set, with ws_flush_pc equal to the head PC; on that edge all entries SHALL be invalidated and count set to 0.
REQ-028 SHALL compute fwd_hit = OR over valid, gr_we, !excp entries whose dest==fwd_raddr, and SHALL force fwd_hit=0 when fwd_raddr==0.
REQ-029 SHALL drive fwd_data from the youngest matching entry, and 0 when fwd_hit=0.
REQ-030 SHALL set pending_mask bit r for each valid, gr_we, !excp entry whose dest is r; bit 0 SHALL be always 0.

Reset
REQ-031 SHALL, on reset, clear count, pointers and all valid bits.
REQ-032 SHALL, with reset asserted, force rf_we=0, ws_flush=0, fwd_hit=0, pending_mask=0 and ws_allowin=0.
REQ-033 SHALL, after reset, leave ws_allowin=1, fwd_data=0, rf_waddr/rf_wdata=0 and ws_flush_pc=0 until the first enqueue.
REQ-034 SHALL, on reset asserted mid-operation, discard queued entries and issue no register write.

Configuration
REQ-035 SHALL, with macro WB_RETIRE_DEBUG_TRACE_EN defined, add outputs debug_wb_pc (PC_W), debug_wb_rf_we (4), debug_wb_rf_wnum (REG_AW) and debug_wb_rf_wdata (DATA_W).
REQ-036 SHALL drive the debug outputs as head PC, {4{rf_we}}, rf_waddr and rf_wdata.
REQ-037 SHALL, without WB_RETIRE_DEBUG_TRACE_EN, omit these ports and their logic entirely.

Verification
REQ-038 SHALL cover: accept gr_we=1, dest=5, result=0x1234 with rf_ready=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, count returns to 0.
REQ-039 SHALL cover: rf_ready=0, offer 3 instructions (DEPTH=2) -> 2 accepted, ws_allowin=0; raise rf_ready -> writes retire in order and the third is accepted on the same edge as the first retire.
REQ-040 SHALL cover: queue holds dest=7 data=0xA then dest=7 data=0xB, fwd_raddr=7 -> fwd_hit=1, fwd_data=0xB, pending_mask[7]=1; fwd_raddr=0 -> fwd_hit=0.
REQ-041 SHALL cover: head excp=1, pc=0x1C000010, younger entry queued -> ws_flush=1 and ws_flush_pc=0x1C000010 for one cycle, no rf_we, queue empty next cycle, offered instruction not accepted.
REQ-042 SHALL cover: reset asserted with 2 entries queued and rf_ready=1 -> no rf_we; after release count=0 and ws_allowin=1.
REQ-043 SHALL cover: DEPTH=3, 10 back-to-back instructions with rf_ready toggling -> all writes in order, pointers wrap, no loss or duplication.

Source files
------------

// File: rtl/wb_retire_queue.sv
// Writeback retire queue: circular FIFO between memory stage and register file write port.
// Optional debug trace outputs are enabled by defining WB_RETIRE_DEBUG_TRACE_EN.
module wb_retire_queue #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ms_to_ws_valid,
    input  logic                   ms_gr_we,
    input  logic [REG_AW-1:0]      ms_dest,
    input  logic [DATA_W-1:0]      ms_result,
    input  logic [PC_W-1:0]        ms_pc,
    input  logic                   ms_excp,
    output logic                   ws_allowin,
    input  logic                   rf_ready,
    output logic                   rf_we,
    output logic [REG_AW-1:0]      rf_waddr,
    output logic [DATA_W-1:0]      rf_wdata,
    input  logic [REG_AW-1:0]      fwd_raddr,
    output logic                   fwd_hit,
    output logic [DATA_W-1:0]      fwd_data,
    output logic [(2**REG_AW)-1:0] pending_mask,
    output logic                   ws_flush,
    output logic [PC_W-1:0]        ws_flush_pc
`ifdef WB_RETIRE_DEBUG_TRACE_EN
    ,
    output logic [PC_W-1:0]        debug_wb_pc,
    output logic [3:0]             debug_wb_rf_we,
    output logic [REG_AW-1:0]      debug_wb_rf_wnum,
    output logic [DATA_W-1:0]      debug_wb_rf_wdata
`endif
);

    localparam int NREG  = 2**REG_AW;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_we;
    logic [DEPTH-1:0]  ent_excp;
    logic [REG_AW-1:0] ent_dest   [DEPTH];
    logic [DATA_W-1:0] ent_result [DEPTH];
    logic [PC_W-1:0]   ent_pc     [DEPTH];

    ptr_t              head;
    ptr_t              tail;
    logic [CNT_W-1:0]  count;

    logic              head_valid;
    logic              retire;
    logic              enqueue;
    logic              fwd_hit_raw;
    logic [DATA_W-1:0] fwd_data_raw;
    logic [NREG-1:0]   pending_raw;

    function automatic ptr_t ptr_inc(input ptr_t p);
        if (p == ptr_t'(DEPTH - 1))
            return '0;
        return p + 1'b1;
    endfunction

    assign head_valid  = ent_valid[head];
    assign ws_flush    = !reset && head_valid && ent_excp[head];
    assign retire      = !reset && head_valid && (!ent_we[head] || ent_excp[head] || rf_ready);
    assign rf_we       = !reset && head_valid && ent_we[head] && !ent_excp[head] && rf_ready;
    assign rf_waddr    = ent_dest[head];
    assign rf_wdata    = ent_result[head];
    assign ws_flush_pc = ent_pc[head];
    assign ws_allowin  = !reset && !ws_flush && ((count < CNT_W'(DEPTH)) || retire);
    assign enqueue     = ms_to_ws_valid && ws_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_valid <= '0;
            ent_we    <= '0;
            ent_excp  <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_dest[i]   <= '0;
                ent_result[i] <= '0;
                ent_pc[i]     <= '0;
            end
        end else if (ws_flush) begin
            ent_valid <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            if (retire) begin
                ent_valid[head] <= 1'b0;
                head            <= ptr_inc(head);
            end
            // When full, head==tail: this later write re-validates the slot just retired.
            if (enqueue) begin
                ent_valid[tail]  <= 1'b1;
                ent_we[tail]     <= ms_gr_we;
                ent_excp[tail]   <= ms_excp;
                ent_dest[tail]   <= ms_dest;
                ent_result[tail] <= ms_result;
                ent_pc[tail]     <= ms_pc;
                tail             <= ptr_inc(tail);
            end
            if (enqueue && !retire)
                count <= count + 1'b1;
            else if (!enqueue && retire)
                count <= count - 1'b1;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest writer.
    always_comb begin
        ptr_t idx;
        idx          = '0;
        fwd_hit_raw  = 1'b0;
        fwd_data_raw = '0;
        pending_raw  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = ptr_t'((32'(head) + k) % DEPTH);
            if (ent_valid[idx] && ent_we[idx] && !ent_excp[idx]) begin
                pending_raw[ent_dest[idx]] = 1'b1;
                if (ent_dest[idx] == fwd_raddr) begin
                    fwd_hit_raw  = 1'b1;
                    fwd_data_raw = ent_result[idx];
                end
            end
        end
        pending_raw[0] = 1'b0;
        if (reset || fwd_raddr == '0) begin
            fwd_hit_raw  = 1'b0;
            fwd_data_raw = '0;
        end
        if (reset)
            pending_raw = '0;
    end

    assign fwd_hit      = fwd_hit_raw;
    assign fwd_data     = fwd_data_raw;
    assign pending_mask = pending_raw;

`ifdef WB_RETIRE_DEBUG_TRACE_EN
    assign debug_wb_pc       = ent_pc[head];
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_retire_queue.sv
// Bench for wb_retire_queue: DEPTH=2 and DEPTH=3 instances share stimulus, each checked
// every cycle against a queue-based reference model, plus directed scenarios.
module tb_wb_retire_queue;

    typedef struct packed {
        logic        we;
        logic        excp;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ms_to_ws_valid, ms_gr_we, ms_excp, rf_ready;
    logic [4:0]  ms_dest, fwd_raddr;
    logic [31:0] ms_result, ms_pc;

    logic        allow2, we2, flush2, hit2;
    logic [4:0]  waddr2;
    logic [31:0] wdata2, fdata2, pend2, fpc2;
    logic        allow3, we3, flush3, hit3;
    logic [4:0]  waddr3;
    logic [31:0] wdata3, fdata3, pend3, fpc3;

    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   wr3      = 0;
    bit   known    = 0;
    bit   fresh2   = 0;
    bit   fresh3   = 0;
    ent_t q2[$];
    ent_t q3[$];

    always #5 clk = ~clk;

    wb_retire_queue #(.DATA_W(32), .REG_AW(5), .PC_W(32), .DEPTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ms_gr_we(ms_gr_we),
        .ms_dest(ms_dest), .ms_result(ms_result), .ms_pc(ms_pc), .ms_excp(ms_excp),
        .ws_allowin(allow2), .rf_ready(rf_ready), .rf_we(we2), .rf_waddr(waddr2),
        .rf_wdata(wdata2), .fwd_raddr(fwd_raddr), .fwd_hit(hit2), .fwd_data(fdata2),
        .pending_mask(pend2), .ws_flush(flush2), .ws_flush_pc(fpc2)
    );

    wb_retire_queue #(.DATA_W(32), .REG_AW(5), .PC_W(32), .DEPTH(3)) u_dut3 (
        .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ms_gr_we(ms_gr_we),
        .ms_dest(ms_dest), .ms_result(ms_result), .ms_pc(ms_pc), .ms_excp(ms_excp),
        .ws_allowin(allow3), .rf_ready(rf_ready), .rf_we(we3), .rf_waddr(waddr3),
        .rf_wdata(wdata3), .fwd_raddr(fwd_raddr), .fwd_hit(hit3), .fwd_data(fdata3),
        .pending_mask(pend3), .ws_flush(flush3), .ws_flush_pc(fpc3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected outputs from the queue contents and the current inputs.
    task automatic eval(input string tag, input ent_t q[$], input int depth, input bit fresh,
                        input logic allow, input logic we, input logic flush, input logic hit,
                        input logic [4:0] waddr, input logic [31:0] wdata, input logic [31:0] fdata,
                        input logic [31:0] pend, input logic [31:0] fpc,
                        output bit retire, output bit acc);
        bit          hv, e_flush, e_we, e_hit;
        logic [31:0] e_data, e_pend;
        hv      = q.size() > 0;
        e_flush = !reset && hv && q[0].excp;
        e_we    = !reset && hv && q[0].we && !q[0].excp && rf_ready;
        retire  = !reset && hv && (!q[0].we || q[0].excp || rf_ready);
        acc     = !reset && !e_flush && (q.size() < depth || retire);
        e_hit   = 0;
        e_data  = '0;
        e_pend  = '0;
        if (!reset) begin
            foreach (q[i]) begin
                if (q[i].we && !q[i].excp) begin
                    e_pend[q[i].dest] = 1'b1;
                    if (q[i].dest == fwd_raddr && fwd_raddr != 0) begin
                        e_hit  = 1;
                        e_data = q[i].result;
                    end
                end
            end
        end
        e_pend[0] = 1'b0;
        check({tag, ".rf_we"},   64'(we),    64'(e_we));
        check({tag, ".flush"},   64'(flush), 64'(e_flush));
        check({tag, ".allowin"}, 64'(allow), 64'(acc));
        check({tag, ".fwd_hit"}, 64'(hit),   64'(e_hit));
        check({tag, ".fwd_data"}, 64'(fdata), 64'(e_data));
        check({tag, ".pending"}, 64'(pend),  64'(e_pend));
        if (hv) begin
            check({tag, ".waddr"},    64'(waddr), 64'(q[0].dest));
            check({tag, ".wdata"},    64'(wdata), 64'(q[0].result));
            check({tag, ".flush_pc"}, 64'(fpc),   64'(q[0].pc));
        end else if (fresh) begin
            check({tag, ".waddr0"},    64'(waddr), 64'd0);
            check({tag, ".wdata0"},    64'(wdata), 64'd0);
            check({tag, ".flush_pc0"}, 64'(fpc),   64'd0);
        end
    endtask

    task automatic step(input bit rst, input bit v, input bit we, input logic [4:0] d,
                        input logic [31:0] r, input logic [31:0] p, input bit ex, input bit rdy,
                        input logic [4:0] fa, output bit a2, output bit a3);
        bit   r2, r3, ac2, ac3;
        ent_t e;
        @(negedge clk);
        reset          = rst;
        ms_to_ws_valid = v;
        ms_gr_we       = we;
        ms_dest        = d;
        ms_result      = r;
        ms_pc          = p;
        ms_excp        = ex;
        rf_ready       = rdy;
        fwd_raddr      = fa;
        #1;
        r2 = 0; r3 = 0; ac2 = 0; ac3 = 0;
        if (known) begin
            eval("d2", q2, 2, fresh2, allow2, we2, flush2, hit2, waddr2, wdata2, fdata2, pend2, fpc2, r2, ac2);
            eval("d3", q3, 3, fresh3, allow3, we3, flush3, hit3, waddr3, wdata3, fdata3, pend3, fpc3, r3, ac3);
            if (we3 === 1'b1)
                wr3++;
        end
        a2 = v && ac2;
        a3 = v && ac3;
        e  = {we, ex, d, r, p};
        @(posedge clk);
        if (rst) begin
            q2.delete();
            q3.delete();
            fresh2 = 1;
            fresh3 = 1;
            known  = 1;
        end else begin
            if (q2.size() > 0 && q2[0].excp) q2.delete();
            else begin
                if (r2) void'(q2.pop_front());
                if (a2) begin q2.push_back(e); fresh2 = 0; end
            end
            if (q3.size() > 0 && q3[0].excp) q3.delete();
            else begin
                if (r3) void'(q3.pop_front());
                if (a3) begin q3.push_back(e); fresh3 = 0; end
            end
        end
    endtask

    task automatic idle(input bit rst, input bit rdy, input logic [4:0] fa);
        bit a2, a3;
        step(rst, 0, 0, 5'd0, 32'd0, 32'd0, 0, rdy, fa, a2, a3);
    endtask

    initial begin
        bit a2, a3;
        int n, base;

        // Reset state and basic single write
        idle(1, 1, 0);
        #1 check("rst.allowin", 64'(allow2), 64'd0);
        idle(1, 1, 0);
        step(0, 1, 1, 5'd5, 32'h1234, 32'h1C00_0000, 0, 1, 0, a2, a3);
        #1;
        check("single.rf_we", 64'(we2), 64'd1);
        check("single.waddr", 64'(waddr2), 64'd5);
        check("single.wdata", 64'(wdata2), 64'h1234);
        idle(0, 1, 0);
        #1 check("single.empty_pending", 64'(pend2), 64'd0);

        // Backpressure on DEPTH=2: third offer held until first retire
        idle(1, 0, 0);
        step(0, 1, 1, 5'd1, 32'h11, 32'h100, 0, 0, 0, a2, a3);
        step(0, 1, 1, 5'd2, 32'h22, 32'h104, 0, 0, 0, a2, a3);
        #1 check("bp.allowin_full", 64'(allow2), 64'd0);
        step(0, 1, 1, 5'd3, 32'h33, 32'h108, 0, 0, 0, a2, a3);
        step(0, 1, 1, 5'd3, 32'h33, 32'h108, 0, 1, 0, a2, a3);
        check("bp.third_accepted_on_retire", 64'(a2), 64'd1);
        repeat (3) idle(0, 1, 0);

        // Forwarding from youngest of two writers to r7
        idle(1, 0, 0);
        step(0, 1, 1, 5'd7, 32'hA, 32'h200, 0, 0, 7, a2, a3);
        step(0, 1, 1, 5'd7, 32'hB, 32'h204, 0, 0, 7, a2, a3);
        #1;
        check("fwd.hit", 64'(hit2), 64'd1);
        check("fwd.data", 64'(fdata2), 64'hB);
        check("fwd.pending7", 64'(pend2[7]), 64'd1);
        idle(0, 0, 0);
        #1 check("fwd.r0_nohit", 64'(hit2), 64'd0);

        // Exception reaching head with a younger entry behind it (DEPTH=3)
        idle(1, 0, 0);
        step(0, 1, 1, 5'd4, 32'h44, 32'h1C00_000C, 0, 0, 0, a2, a3);
        step(0, 1, 1, 5'd6, 32'h66, 32'h1C00_0010, 1, 0, 0, a2, a3);
        step(0, 1, 1, 5'd8, 32'h88, 32'h1C00_0014, 0, 0, 0, a2, a3);
        step(0, 1, 1, 5'd9, 32'h99, 32'h1C00_0018, 0, 1, 0, a2, a3);
        #1;
        check("excp.flush", 64'(flush3), 64'd1);
        check("excp.flush_pc", 64'(fpc3), 64'h1C00_0010);
        check("excp.no_rf_we", 64'(we3), 64'd0);
        check("excp.allowin", 64'(allow3), 64'd0);
        step(0, 1, 1, 5'd9, 32'h99, 32'h1C00_0018, 0, 1, 0, a2, a3);
        check("excp.offer_refused", 64'(a3), 64'd0);
        #1 check("excp.flush_one_cycle", 64'(flush3), 64'd0);
        repeat (3) idle(0, 1, 0);

        // Reset mid-operation with entries queued
        idle(1, 0, 0);
        step(0, 1, 1, 5'd10, 32'hAA, 32'h300, 0, 0, 0, a2, a3);
        step(0, 1, 1, 5'd11, 32'hBB, 32'h304, 0, 0, 0, a2, a3);
        idle(1, 1, 0);
        #1 check("rst_mid.no_rf_we", 64'(we2), 64'd0);
        idle(0, 1, 0);
        #1 check("rst_mid.allowin", 64'(allow2), 64'd1);

        // Ten back-to-back writes through DEPTH=3 with toggling rf_ready
        idle(1, 0, 0);
        n    = 0;
        base = wr3;
        for (int c = 0; c < 60 && n < 10; c++) begin
            step(0, 1, 1, 5'(n + 1), 32'h500 + 32'(n), 32'h400 + 32'(4 * n), 0, (c % 2) == 1, 5'(n), a2, a3);
            if (a3) n++;
        end
        check("b2b.accepted", 64'(n), 64'd10);
        repeat (8) idle(0, 1, 0);
        check("b2b.writes", 64'(wr3 - base), 64'd10);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                 5'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), a2, a3);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
